meas_seq_ctrl: RTL and testbench

//  Sequencer for the capture->FFT->CORDIC->peak-find->root->DDS measurement chain. Per run:

---
 rtl/meas_ctrl_pkg.sv | 15 +
 rtl/dds_word_calc.sv | 55 +++++
 rtl/meas_seq_ctrl.sv | 179 +++++++++++++++++
 tb/tb_meas_seq_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/meas_ctrl_pkg.sv
// Shared types for the measurement sequencer.
//  state_t  : sequencer FSM states
//  ERR_*    : bit positions in the sticky error register
//  AMP_MAX  : saturation ceiling for the amplitude word
package meas_ctrl_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_FLUSH, S_FILL, S_WAIT_RDY, S_STREAM, S_ROOT, S_CFG, S_DONE
  } state_t;

  localparam int ERR_OVF = 0;
  localparam int ERR_TMO = 1;
  localparam int ERR_W   = 2;

  localparam logic [15:0] AMP_MAX = 16'hFFFF;
endpackage

// File: rtl/dds_word_calc.sv
// DDS configuration word calculator, one cycle of latency.
//  en        : load strobe; operands sampled this cycle
//  peak_addr : FFT peak bin
//  root_data : unsigned root amplitude
//  pinc_q    : peak_addr * PINC_STEP (mod 2^32), held between loads
//  amp_q     : root_data >> AMP_SHIFT, saturated to AMP_MAX, held between loads
//  vld_q     : one-cycle strobe the cycle after en
module dds_word_calc
  import meas_ctrl_pkg::*;
#(
  parameter int          ADDR_WIDTH = 8,
  parameter int          ROOT_WIDTH = 25,
  parameter logic [31:0] PINC_STEP  = 32'h0080_0000,
  parameter int          AMP_SHIFT  = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [ADDR_WIDTH-1:0] peak_addr,
  input  logic [ROOT_WIDTH-1:0] root_data,
  output logic [31:0]           pinc_q,
  output logic [15:0]           amp_q,
  output logic                  vld_q
);
  // widened so any ROOT_WIDTH/AMP_SHIFT combination can be compared against 16 bits
  localparam int EW = ROOT_WIDTH + 16;

  logic [EW-1:0] root_sh;
  logic [31:0]   pinc_d;
  logic [15:0]   amp_d;
  logic          vld_d;

  always_comb begin
    root_sh = {16'b0, root_data} >> AMP_SHIFT;
    pinc_d  = pinc_q;
    amp_d   = amp_q;
    vld_d   = en;
    if (en) begin
      pinc_d = 32'(peak_addr) * PINC_STEP;
      amp_d  = (root_sh > EW'(AMP_MAX)) ? AMP_MAX : root_sh[15:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pinc_q <= '0;
      amp_q  <= '0;
      vld_q  <= 1'b0;
    end else begin
      pinc_q <= pinc_d;
      amp_q  <= amp_d;
      vld_q  <= vld_d;
    end
  end
endmodule

// File: rtl/meas_seq_ctrl.sv
// Measurement chain sequencer: flush/fill sample FIFO, release FFT reader,
// capture peak bin and root amplitude, program the DDS.
//  start/cont            : run request (IDLE only) / auto re-run after DONE
//  fifo_srst/fifo_wr_en  : FIFO flush pulse and write enable, sample_idx with writes
//  fifo_full             : overflow detect during FILL
//  fft_rst_done/rd_go    : FFT ready handshake / FIFO reader release
//  peak_*/root_*         : result strobes and data from the datapath
//  dds_cfg_*/amp_word    : DDS config strobe+phase increment, amplitude word
//  busy/done/err_*       : status; errors sticky until the next start
// Optional build macro MEAS_TIMEOUT_EN adds a watchdog on WAIT_RDY/STREAM/ROOT.
module meas_seq_ctrl
  import meas_ctrl_pkg::*;
#(
  parameter int          DATA_NUM       = 512,
  parameter int          CNT_WIDTH      = 10,
  parameter int          ADDR_WIDTH     = 8,
  parameter int          ROOT_WIDTH     = 25,
  parameter logic [31:0] PINC_STEP      = 32'h0080_0000,
  parameter int          AMP_SHIFT      = 9,
  parameter int          FLUSH_CYCLES   = 2,
  parameter int          TIMEOUT_CYCLES = 4096
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  cont,
  output logic                  fifo_srst,
  output logic                  fifo_wr_en,
  output logic [CNT_WIDTH-1:0]  sample_idx,
  input  logic                  fifo_full,
  input  logic                  fft_rst_done,
  output logic                  rd_go,
  input  logic                  peak_valid,
  input  logic [ADDR_WIDTH-1:0] peak_addr,
  input  logic                  root_valid,
  input  logic [ROOT_WIDTH-1:0] root_data,
  output logic                  dds_cfg_tvalid,
  output logic [31:0]           dds_cfg_tdata,
  output logic [15:0]           amp_word,
  output logic                  busy,
  output logic                  done,
  output logic                  err_ovf,
  output logic                  err_timeout
);
  localparam logic [CNT_WIDTH-1:0] LAST_IDX   = CNT_WIDTH'(DATA_NUM - 1);
  localparam logic [CNT_WIDTH-1:0] LAST_FLUSH = CNT_WIDTH'(FLUSH_CYCLES - 1);

  state_t                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]  peak_q, peak_d;
  logic [ROOT_WIDTH-1:0]  root_q, root_d;
  logic [ERR_W-1:0]       err_q, err_d;
  logic                   cfg_vld;

`ifdef MEAS_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    peak_d  = peak_q;
    root_d  = root_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE:
        if (start) begin
          err_d   = '0;
          cnt_d   = '0;
          state_d = S_FLUSH;
        end
      // cnt is shared: flush length first, then sample index
      S_FLUSH:
        if (cnt_q == LAST_FLUSH) begin
          cnt_d   = '0;
          state_d = S_FILL;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      S_FILL: begin
        cnt_d = cnt_q + 1'b1;
        if (fifo_full && (cnt_q != LAST_IDX)) begin
          err_d[ERR_OVF] = 1'b1;
          cnt_d          = '0;
          state_d        = S_IDLE;
        end else if (cnt_q == LAST_IDX) begin
          cnt_d   = '0;
          state_d = S_WAIT_RDY;
        end
      end
      S_WAIT_RDY:
        if (fft_rst_done) state_d = S_STREAM;
      S_STREAM:
        if (peak_valid) begin
          peak_d = peak_addr;
          if (root_valid) begin
            root_d  = root_data;
            state_d = S_CFG;
          end else begin
            state_d = S_ROOT;
          end
        end
      S_ROOT:
        if (root_valid) begin
          root_d  = root_data;
          state_d = S_CFG;
        end
      S_CFG:   state_d = S_DONE;
      S_DONE:  state_d = cont ? S_FLUSH : S_IDLE;
      default: state_d = S_IDLE;
    endcase
`ifdef MEAS_TIMEOUT_EN
    // counter restarts on every state change, so each wait gets the full budget
    tmo_d = '0;
    if ((state_q inside {S_WAIT_RDY, S_STREAM, S_ROOT}) && (state_d == state_q)) begin
      if (tmo_q == TMO_LAST) begin
        err_d[ERR_TMO] = 1'b1;
        state_d        = S_IDLE;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
`else
    // no watchdog: WAIT_RDY/STREAM/ROOT wait for their strobes indefinitely
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      peak_q  <= '0;
      root_q  <= '0;
      err_q   <= '0;
`ifdef MEAS_TIMEOUT_EN
      tmo_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      peak_q  <= peak_d;
      root_q  <= root_d;
      err_q   <= err_d;
`ifdef MEAS_TIMEOUT_EN
      tmo_q   <= tmo_d;
`endif
    end
  end

  // words are computed during CFG and land (with the strobe) in DONE
  dds_word_calc #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .ROOT_WIDTH (ROOT_WIDTH),
    .PINC_STEP  (PINC_STEP),
    .AMP_SHIFT  (AMP_SHIFT)
  ) u_calc (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (state_q == S_CFG),
    .peak_addr (peak_q),
    .root_data (root_q),
    .pinc_q    (dds_cfg_tdata),
    .amp_q     (amp_word),
    .vld_q     (cfg_vld)
  );

  // state-decoded outputs so an async reset clears them in the same cycle
  assign busy           = (state_q != S_IDLE);
  assign fifo_srst      = (state_q == S_FLUSH);
  assign fifo_wr_en     = (state_q == S_FILL);
  assign sample_idx     = fifo_wr_en ? cnt_q : '0;
  assign rd_go          = (state_q == S_STREAM);
  assign dds_cfg_tvalid = cfg_vld;
  assign done           = cfg_vld;
  assign err_ovf        = err_q[ERR_OVF];
  assign err_timeout    = err_q[ERR_TMO];
endmodule

// File: tb/tb_meas_seq_ctrl.sv
module tb_meas_seq_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        start1 = 0, start2 = 0, cont = 0, fifo_full = 0, fft_rst_done = 0;
  logic        peak_valid = 0, root_valid = 0;
  logic [7:0]  peak_addr = 0;
  logic [24:0] root_data = 0;

  typedef struct packed {
    logic        srst;
    logic        wr;
    logic [9:0]  idx;
    logic        rd_go;
    logic        tv;
    logic [31:0] td;
    logic [15:0] amp;
    logic        busy;
    logic        done;
    logic        ovf;
    logic        tmo;
  } dut_out_t;

  wire dut_out_t o1, o2;

  meas_seq_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .start(start1), .cont(cont),
    .fifo_srst(o1.srst), .fifo_wr_en(o1.wr), .sample_idx(o1.idx), .fifo_full(fifo_full),
    .fft_rst_done(fft_rst_done), .rd_go(o1.rd_go), .peak_valid(peak_valid), .peak_addr(peak_addr),
    .root_valid(root_valid), .root_data(root_data), .dds_cfg_tvalid(o1.tv), .dds_cfg_tdata(o1.td),
    .amp_word(o1.amp), .busy(o1.busy), .done(o1.done), .err_ovf(o1.ovf), .err_timeout(o1.tmo)
  );

  meas_seq_ctrl #(.AMP_SHIFT(4), .TIMEOUT_CYCLES(100)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .cont(cont),
    .fifo_srst(o2.srst), .fifo_wr_en(o2.wr), .sample_idx(o2.idx), .fifo_full(fifo_full),
    .fft_rst_done(fft_rst_done), .rd_go(o2.rd_go), .peak_valid(peak_valid), .peak_addr(peak_addr),
    .root_valid(root_valid), .root_data(root_data), .dds_cfg_tvalid(o2.tv), .dds_cfg_tdata(o2.td),
    .amp_word(o2.amp), .busy(o2.busy), .done(o2.done), .err_ovf(o2.ovf), .err_timeout(o2.tmo)
  );

  int n_cmp = 0, n_bad = 0, dv_err = 0;

  // done and dds_cfg_tvalid must be the same pulse on every cycle
  always @(negedge clk) if ((o1.done !== o1.tv) || (o2.done !== o2.tv)) dv_err++;

  initial begin
    #2ms;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic dut_out_t cur(input int sel);
    return (sel != 0) ? o2 : o1;
  endfunction

  function automatic logic [63:0] ctrl_bits(input dut_out_t c);
    return {45'b0, c.srst, c.wr, c.idx, c.rd_go, c.tv, c.busy, c.done, c.ovf, c.tmo};
  endfunction

  task automatic start_run(input int sel, input string nm);
    dut_out_t c;
    if (sel != 0) start2 = 1'b1; else start1 = 1'b1;
    step();
    start1 = 1'b0;
    start2 = 1'b0;
    c = cur(sel);
    chk({nm, "_flush_errclr"}, {c.srst, c.busy, c.ovf, c.tmo}, 4'b1100);
  endtask

  task automatic wait_stream(input int sel, input string nm);
    dut_out_t c;
    int n = 0;
    c = cur(sel);
    while (!c.rd_go && n < 2000) begin
      step();
      n++;
      c = cur(sel);
    end
    chk({nm, "_reach_stream"}, c.rd_go, 1'b1);
  endtask

  task automatic stream_part(input int sel, input logic [7:0] pk, input logic [24:0] rt,
                             input bit coinc, input logic [31:0] exp_td,
                             input logic [15:0] exp_amp, input bit exp_cont, input string nm);
    dut_out_t c;
    step();
    step();
    peak_valid = 1'b1;
    peak_addr  = pk;
    if (coinc) begin
      root_valid = 1'b1;
      root_data  = rt;
    end
    step();
    peak_valid = 1'b0;
    root_valid = 1'b0;
    peak_addr  = ~pk;
    if (!coinc) begin
      c = cur(sel);
      chk({nm, "_in_root"}, {c.rd_go, c.busy}, 2'b01);
      peak_valid = 1'b1;    // stray peak strobe in ROOT must be ignored
      step();
      peak_valid = 1'b0;
      step();
      root_valid = 1'b1;
      root_data  = rt;
      step();
      root_valid = 1'b0;
    end
    root_data = ~rt;
    c = cur(sel);
    chk({nm, "_cfg_no_done"}, {c.done, c.rd_go, c.busy}, 3'b001);
    step();
    c = cur(sel);
    chk({nm, "_done"}, {c.done, c.tv}, 2'b11);
    chk({nm, "_tdata"}, c.td, exp_td);
    chk({nm, "_amp"}, c.amp, exp_amp);
    step();
    c = cur(sel);
    chk({nm, "_after"}, {c.done, c.busy, c.srst, c.amp, c.td},
        {1'b0, exp_cont, exp_cont, exp_amp, exp_td});
  endtask

  typedef struct {
    int          sel;
    logic [7:0]  pk;
    logic [24:0] rt;
    bit          coinc;
    logic [31:0] td;
    logic [15:0] amp;
  } vec_t;

  vec_t vt[10];

  initial begin
    dut_out_t c;
    int n;
    int bad;

    vt[0] = '{0, 8'd10,  25'd1000000,   0, 32'h0500_0000, 16'd1953};
    vt[1] = '{0, 8'd0,   25'd0,         1, 32'h0000_0000, 16'h0000};
    vt[2] = '{0, 8'd255, 25'h1FF_FFFF,  0, 32'h7F80_0000, 16'hFFFF};
    vt[3] = '{0, 8'd200, 25'd512,       1, 32'h6400_0000, 16'h0001};
    vt[4] = '{0, 8'd1,   25'd511,       0, 32'h0080_0000, 16'h0000};
    vt[5] = '{0, 8'd128, 25'h12_3456,   0, 32'h4000_0000, 16'h091A};
    vt[6] = '{1, 8'd3,   25'h1FF_FFFF,  1, 32'h0180_0000, 16'hFFFF};
    vt[7] = '{1, 8'd4,   25'h0F_FFF0,   0, 32'h0200_0000, 16'hFFFF};
    vt[8] = '{1, 8'd5,   25'h10_0000,   0, 32'h0280_0000, 16'hFFFF};
    vt[9] = '{1, 8'd6,   25'h01_2345,   1, 32'h0300_0000, 16'h1234};

    // reset
    #2 rst_n = 1'b0;
    #3;
    chk("reset_ctrl1", ctrl_bits(o1), 64'd0);
    chk("reset_words1", {o1.td, o1.amp}, 64'd0);
    chk("reset_ctrl2", ctrl_bits(o2), 64'd0);
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("idle_after_reset", ctrl_bits(o1), 64'd0);

    // run 1: flush/fill timing, start ignored mid-fill, WAIT_RDY hold
    start_run(0, "t1");
    step();
    chk("t1_flush2", {o1.srst, o1.wr}, 2'b10);
    step();
    bad = 0;
    for (int i = 0; i < 512; i++) begin
      if (!(o1.wr === 1'b1 && o1.idx === 10'(i) && o1.srst === 1'b0)) bad++;
      start1 = (i == 50);
      step();
    end
    start1 = 1'b0;
    chk("t1_fill_bad_cycles", bad, 0);
    chk("t1_fill_end", {o1.wr, o1.idx, o1.busy, o1.rd_go}, {1'b0, 10'd0, 1'b1, 1'b0});
    step();
    step();
    step();
    chk("t1_wait_rdy_hold", {o1.rd_go, o1.busy}, 2'b01);
    fft_rst_done = 1'b1;
    step();
    chk("t1_stream_rd_go", o1.rd_go, 1'b1);
    stream_part(0, 8'd10, 25'd1000000, 0, 32'h0500_0000, 16'd1953, 0, "t1");

    // overflow at sample_idx 100, start mid-run ignored
    start_run(0, "t4");
    step();
    step();
    for (int i = 0; i < 100; i++) begin
      start1 = (i == 20);
      step();
    end
    start1 = 1'b0;
    chk("t4_idx100", {o1.wr, o1.idx}, {1'b1, 10'd100});
    fifo_full = 1'b1;
    step();
    fifo_full = 1'b0;
    chk("t4_ovf", {o1.wr, o1.ovf, o1.busy}, 3'b010);
    step();
    chk("t4_ovf_sticky", {o1.ovf, o1.busy}, 2'b10);

    // table runs
    foreach (vt[k]) begin
      string nm;
      nm = $sformatf("v%0d", k);
      start_run(vt[k].sel, nm);
      wait_stream(vt[k].sel, nm);
      stream_part(vt[k].sel, vt[k].pk, vt[k].rt, vt[k].coinc, vt[k].td, vt[k].amp, 0, nm);
    end

    // no peak_valid on the short-watchdog instance
    start_run(1, "t5");
    wait_stream(1, "t5");
    n = 0;
    c = cur(1);
    while (c.rd_go && n < 300) begin
      step();
      n++;
      c = cur(1);
    end
`ifdef MEAS_TIMEOUT_EN
    chk("t5_tmo_cycles", n, 100);
    chk("t5_tmo_state", {c.busy, c.tmo, c.tv, c.rd_go}, 4'b0100);
    start_run(1, "t5b");
    wait_stream(1, "t5b");
`else
    chk("t5_no_tmo_cycles", n, 300);
    chk("t5_no_tmo_state", {c.rd_go, c.busy, c.tmo}, 3'b110);
`endif
    stream_part(1, 8'd7, 25'h70, 1, 32'h0380_0000, 16'h0007, 0, "t5");

    // async reset mid-STREAM
    start_run(0, "t6");
    wait_stream(0, "t6");
    step();
    rst_n = 1'b0;
    #1;
    chk("t6_rst_ctrl", ctrl_bits(o1), 64'd0);
    chk("t6_rst_words", {o1.td, o1.amp}, 64'd0);
    #3 rst_n = 1'b1;
    step();

    // cont=1: DONE goes straight back to FLUSH
    cont = 1'b1;
    start_run(0, "t7");
    wait_stream(0, "t7");
    stream_part(0, 8'd9, 25'h2400, 1, 32'h0480_0000, 16'h0012, 1, "t7");
    cont = 1'b0;
    step();
    chk("t7_flush2", {o1.srst, o1.busy}, 2'b11);
    step();
    chk("t7_fill0", {o1.wr, o1.idx}, {1'b1, 10'd0});

    chk("done_eq_tvalid", dv_err, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
